countdown_display: RTL and testbench

Consumer side of the countdown digit bus. Takes the three BCD digits and the one-second pulse that the countdown timer publishes, and drives a 3-digit multiplexed 7-segment display. It detects the low-time and expiry conditions and reports them back to the game controller: a level-type `warn` flag and a one-cycle `expired` pulse. It sits between the countdown timer, the controller and the board display pins.

---
 rtl/bomb_pkg.sv | 22 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/countdown_display.sv | 166 ++++++++++++++++
 tb/tb_countdown_display.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game display blocks: controller state
// codes, the display FSM state type and fixed segment patterns.
package bomb_pkg;

  // Game controller state codes published on the game_state bus
  localparam logic [7:0] GS_ARMED    = 8'h10;
  localparam logic [7:0] GS_DEFUSED  = 8'h20;
  localparam logic [7:0] GS_EXPLODED = 8'h30;

  // Display FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } disp_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
// Non-decimal codes 10..15 show a dash so corrupt digits are visible.
module bcd_to_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  import bomb_pkg::*;

  // Pattern lookup; the default covers the non-decimal codes
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = 7'h40;
      4'd1: seg_n = 7'h79;
      4'd2: seg_n = 7'h24;
      4'd3: seg_n = 7'h30;
      4'd4: seg_n = 7'h19;
      4'd5: seg_n = 7'h12;
      4'd6: seg_n = 7'h02;
      4'd7: seg_n = 7'h78;
      4'd8: seg_n = 7'h00;
      4'd9: seg_n = 7'h10;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// Countdown display consumer: scans three BCD digits onto a multiplexed
// 7-segment display, blinks it while time is low or expired, and reports
// a level warn flag and a one-cycle expired pulse to the game controller.
module countdown_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int WARN_SECS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] game_state,
  input  logic       sec_timer,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       warn,
  output logic       expired
);
  import bomb_pkg::*;

  localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);
  localparam logic [9:0]           WARN_LIMIT   = 10'(WARN_SECS);

  logic                 armed;
  logic [9:0]           secs;
  logic                 expire_cond;
  disp_state_t          state_reg, state_next;
  logic                 blinking_next;
  logic                 state_change;
  logic                 expired_next;
  logic                 warn_next;
  logic [REFRESH_W-1:0] refresh_cnt_reg;
  logic [1:0]           scan_idx_reg;
  logic [BLINK_W-1:0]   blink_cnt_reg;
  logic                 blink_phase_reg;
  logic [3:0]           scan_digit;
  logic [2:0]           scan_an;
  logic [2:0]           an_next;
  logic [6:0]           seg_decoded;
  logic [6:0]           seg_n_reg;
  logic [2:0]           an_n_reg;
  logic                 warn_reg;
  logic                 expired_reg;

  // Seconds remaining; wraps modulo 1024 if non-decimal digits are present
  assign armed       = (game_state == GS_ARMED);
  assign secs        = 10'(value_three) * 10'd100 + 10'(value_two) * 10'd10 + 10'(value_one);
  assign expire_cond = (secs == 10'd0) && sec_timer;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: disarm beats expiry, expiry beats warn
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (armed) state_next = RUN;
      end
      RUN: begin
        if (!armed)                  state_next = IDLE;
        else if (expire_cond)        state_next = EXPIRED;
        else if (secs <= WARN_LIMIT) state_next = WARN;
      end
      WARN: begin
        if (!armed)           state_next = IDLE;
        else if (expire_cond) state_next = EXPIRED;
      end
      EXPIRED: begin
        if (!armed) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags derived from the transition being taken this cycle
  assign blinking_next = (state_next == WARN) || (state_next == EXPIRED);
  assign state_change  = (state_next != state_reg);
  assign expired_next  = (state_next == EXPIRED) &&
                         ((state_reg == RUN) || (state_reg == WARN));
  assign warn_next     = (state_next == WARN);

  // Free-running scan slot timer and digit index
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt_reg <= '0;
      scan_idx_reg    <= 2'd0;
    end else if (refresh_cnt_reg == REFRESH_LAST) begin
      refresh_cnt_reg <= '0;
      scan_idx_reg    <= (scan_idx_reg == 2'd2) ? 2'd0 : scan_idx_reg + 2'd1;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end

  // Blink timer: restarts on every entry to a blinking state, idle otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (blinking_next && !state_change) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end else begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end
  end

  // Digit mux: index 0 is the right-hand units digit
  always_comb begin
    scan_digit = value_one;
    case (scan_idx_reg)
      2'd1:    scan_digit = value_two;
      2'd2:    scan_digit = value_three;
      default: scan_digit = value_one;
    endcase
  end

  // One active-low enable per digit position
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_an
      assign scan_an[gi] = (scan_idx_reg != 2'(gi));
    end
  endgenerate

  assign an_next = blink_phase_reg ? 3'b111 : scan_an;

  bcd_to_seg u_bcd_to_seg (
    .bcd   (scan_digit),
    .seg_n (seg_decoded)
  );

  // Output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_n_reg   <= SEG_BLANK;
      an_n_reg    <= 3'b111;
      warn_reg    <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      seg_n_reg   <= seg_decoded;
      an_n_reg    <= an_next;
      warn_reg    <= warn_next;
      expired_reg <= expired_next;
    end
  end

  assign seg_n   = seg_n_reg;
  assign an_n    = an_n_reg;
  assign warn    = warn_reg;
  assign expired = expired_reg;

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display with small dividers.
// A behavioural model tracks time in slots/blink windows and the game rules.
module tb_countdown_display;

  localparam int RD = 4;
  localparam int BD = 8;
  localparam int WS = 10;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WARN = 2;
  localparam int M_EXP  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] game_state = 8'h00;
  logic       sec_timer = 1'b0;
  logic [3:0] value_three = 4'd0;
  logic [3:0] value_two = 4'd0;
  logic [3:0] value_one = 4'd0;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic       warn;
  logic       expired;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state
  int         m_st = M_IDLE;
  int         m_tick = 0;   // cycles since scan restart
  int         m_btick = 0;  // cycles spent in the current blinking state
  logic [6:0] m_seg = 7'h7F;
  logic [2:0] m_an = 3'b111;
  logic       m_warn = 1'b0;
  logic       m_exp = 1'b0;

  countdown_display #(
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD),
    .WARN_SECS   (WS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .game_state  (game_state),
    .sec_timer   (sec_timer),
    .value_three (value_three),
    .value_two   (value_two),
    .value_one   (value_one),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .warn        (warn),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model update for one clock edge, using the inputs present before the edge.
  // Slot = tick / RD (mod 3); blink phase = (btick / BD) odd.
  task automatic model_edge();
    int         slot;
    int         secs;
    int         nxt;
    bit         armed;
    bit         zero_tick;
    logic [3:0] dig;
    if (!reset) begin
      m_st = M_IDLE; m_tick = 0; m_btick = 0;
      m_seg = 7'h7F; m_an = 3'b111; m_warn = 1'b0; m_exp = 1'b0;
      return;
    end
    slot = (m_tick / RD) % 3;
    dig = (slot == 0) ? value_one : (slot == 1) ? value_two : value_three;
    m_seg = seg_of(dig);
    if (((m_btick / BD) % 2) == 1) m_an = 3'b111;
    else m_an = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
    armed = (game_state == 8'h10);
    secs = (int'(value_three) * 100 + int'(value_two) * 10 + int'(value_one)) % 1024;
    zero_tick = (secs == 0) && sec_timer;
    if (!armed) nxt = M_IDLE;
    else if (m_st == M_IDLE) nxt = M_RUN;
    else if ((m_st == M_RUN || m_st == M_WARN) && zero_tick) nxt = M_EXP;
    else if (m_st == M_RUN && secs <= WS) nxt = M_WARN;
    else nxt = m_st;
    m_exp = (m_st == M_RUN || m_st == M_WARN) && (nxt == M_EXP);
    m_warn = (nxt == M_WARN);
    if ((nxt == M_WARN || nxt == M_EXP) && nxt == m_st) m_btick++;
    else m_btick = 0;
    m_tick = (m_tick + 1) % (3 * RD);
    m_st = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    game_state = 8'h10;
    value_one = 4'd3;
    repeat (3) step();
    total_cnt++;
    if ({seg_n, an_n, warn, expired} !== {7'h7F, 3'b111, 1'b0, 1'b0}) begin
      $display("FAIL reset_state: got seg=%h an=%b warn=%b exp=%b, want 7f 111 0 0",
               seg_n, an_n, warn, expired);
    end else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_scan();
    logic [2:0] want_an;
    logic [6:0] want_seg;
    game_state = 8'h00;
    value_three = 4'd2; value_two = 4'd0; value_one = 4'd0;
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      want_an  = (k < 4) ? 3'b110 : (k < 8) ? 3'b101 : 3'b011;
      want_seg = (k < 8) ? 7'h40 : 7'h24;
      total_cnt++;
      if (an_n !== want_an || seg_n !== want_seg || warn !== 1'b0) begin
        $display("FAIL scan_k%0d: got an=%b seg=%h warn=%b, want an=%b seg=%h warn=0",
                 k, an_n, seg_n, warn, want_an, want_seg);
      end else pass_cnt++;
    end
    $display("test_scan: done");
  endtask

  task automatic test_warn();
    int  run_len;
    int  windows;
    game_state = 8'h10;
    value_three = 4'd0; value_two = 4'd1; value_one = 4'd1;
    repeat (6) step();
    total_cnt++;
    if (warn !== 1'b0) $display("FAIL warn_at_11s: got warn=%b, want 0", warn);
    else pass_cnt++;
    value_one = 4'd0;
    step();
    total_cnt++;
    if (warn !== 1'b1) $display("FAIL warn_rise: got warn=%b, want 1", warn);
    else pass_cnt++;
    run_len = 0;
    windows = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      total_cnt++;
      if ({seg_n, an_n, warn, expired} !== {m_seg, m_an, m_warn, m_exp}) begin
        $display("FAIL warn_model_k%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", k,
                 seg_n, an_n, warn, expired, m_seg, m_an, m_warn, m_exp);
      end else pass_cnt++;
      if (an_n === 3'b111) run_len++;
      else if (run_len != 0) begin
        windows++;
        total_cnt++;
        if (run_len != BD) $display("FAIL blank_window: got %0d clk, want %0d", run_len, BD);
        else pass_cnt++;
        run_len = 0;
      end
    end
    total_cnt++;
    if (windows < 2) $display("FAIL blank_windows_seen: got %0d, want >=2", windows);
    else pass_cnt++;
    $display("test_warn: done");
  endtask

  task automatic test_expire();
    int extra;
    value_three = 4'd0; value_two = 4'd0; value_one = 4'd0;
    sec_timer = 1'b1;
    step();
    sec_timer = 1'b0;
    total_cnt++;
    if (expired !== 1'b1) $display("FAIL expired_pulse: got %b, want 1", expired);
    else pass_cnt++;
    step();
    total_cnt++;
    if (expired !== 1'b0) $display("FAIL expired_one_clk: got %b, want 0", expired);
    else pass_cnt++;
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      sec_timer = (k % 3 == 0);
      step();
      if (expired === 1'b1) extra++;
    end
    sec_timer = 1'b0;
    total_cnt++;
    if (extra != 0) $display("FAIL expired_rearm: got %0d pulses, want 0", extra);
    else pass_cnt++;
    $display("test_expire: done");
  endtask

  task automatic test_simultaneous();
    game_state = 8'h00;
    step();
    game_state = 8'h10;
    value_three = 4'd0; value_two = 4'd0; value_one = 4'd0;
    repeat (3) step();
    sec_timer = 1'b1;
    game_state = 8'h20;
    step();
    sec_timer = 1'b0;
    total_cnt++;
    if (expired !== 1'b0 || warn !== 1'b0)
      $display("FAIL simul_disarm: got exp=%b warn=%b, want 0 0", expired, warn);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if (expired !== 1'b0 || warn !== 1'b0 || an_n === 3'b111)
      $display("FAIL simul_idle: got exp=%b warn=%b an=%b, want 0 0 steady", expired, warn, an_n);
    else pass_cnt++;
    $display("test_simultaneous: done");
  endtask

  task automatic test_dash();
    int seen;
    game_state = 8'h00;
    value_one = 4'hC;
    seen = 0;
    step();
    for (int k = 0; k < 12; k++) begin
      step();
      if (an_n === 3'b110) begin
        seen++;
        total_cnt++;
        if (seg_n !== 7'h3F) $display("FAIL dash_units: got seg=%h, want 3f", seg_n);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (seen != RD) $display("FAIL dash_slot_seen: got %0d, want %0d", seen, RD);
    else pass_cnt++;
    $display("test_dash: done");
  endtask

  task automatic test_reset_mid();
    game_state = 8'h10;
    value_three = 4'd0; value_two = 4'd0; value_one = 4'd5;
    repeat (13) step();
    total_cnt++;
    if (warn !== 1'b1 || an_n !== 3'b111)
      $display("FAIL mid_blink_setup: got warn=%b an=%b, want 1 111", warn, an_n);
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if ({seg_n, an_n, warn, expired} !== {7'h7F, 3'b111, 1'b0, 1'b0})
      $display("FAIL mid_reset: got seg=%h an=%b warn=%b exp=%b, want 7f 111 0 0",
               seg_n, an_n, warn, expired);
    else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++;
    if (an_n !== 3'b110 || seg_n !== 7'h12)
      $display("FAIL scan_restart: got an=%b seg=%h, want 110 12", an_n, seg_n);
    else pass_cnt++;
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      total_cnt++;
      if ({seg_n, an_n, warn, expired} !== {m_seg, m_an, m_warn, m_exp}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_k%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", k,
                   seg_n, an_n, warn, expired, m_seg, m_an, m_warn, m_exp);
      end else pass_cnt++;
      reset = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 19))
        0:       game_state = 8'h20;
        1:       game_state = 8'(($urandom_range(0, 3)) << 4);
        default: game_state = 8'h10;
      endcase
      sec_timer = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          value_three = 4'($urandom_range(0, 15));
          value_two   = 4'($urandom_range(0, 15));
          value_one   = 4'($urandom_range(0, 15));
        end else begin
          value_three = 4'd0;
          value_two   = 4'($urandom_range(0, 1));
          value_one   = 4'($urandom_range(0, 9));
        end
      end
    end
    sec_timer = 1'b0;
    reset = 1'b1;
    $display("test_random: done, %0d cycles", 3000);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_warn();
    test_expire();
    test_simultaneous();
    test_dash();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
